// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder and its helpers.
package mem_pkg;

  // Access width, encoded as the load/store funct3 field.
  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_e;

  // Responder transaction state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word address of the memory-mapped input word.
  localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0001_FFFC;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the memory stage and the responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_width;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_width, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_width, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_lsu_align.sv
// Little-endian lane steering for one access: byte enables, shifted store
// data, extended load result and the error flag (misaligned or illegal width).
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  width,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        err
);
  logic [31:0] rsh;

  // Bring the addressed lane down to bit 0 for extension.
  assign rsh = rword >> {addr_lo, 3'b000};

  // Decode width into enables, replicated write data and extended read data;
  // an error suppresses both the write enables and the read result.
  always_comb begin
    be       = 4'b0000;
    wdata_sh = 32'd0;
    rdata    = 32'd0;
    err      = 1'b0;
    case (width)
      MW_B, MW_BU: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
        rdata    = (width == MW_B) ? {{24{rsh[7]}}, rsh[7:0]} : {24'd0, rsh[7:0]};
        err      = we && (width == MW_BU);
      end
      MW_H, MW_HU: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        rdata    = (width == MW_H) ? {{16{rsh[15]}}, rsh[15:0]} : {16'd0, rsh[15:0]};
        err      = addr_lo[0] || (we && (width == MW_HU));
      end
      MW_W: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        rdata    = rword;
        err      = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      be    = 4'b0000;
      rdata = 32'd0;
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time over a valid/ready
// handshake, performs the access after LATENCY cycles and holds the response
// until the core consumes it. Owns the data RAM and the memory-mapped ioin word.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 17,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  input  logic [31:0]       ioin
);
  localparam int         WORDS    = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] ram [WORDS];

  state_e      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  width_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic                  accept;
  logic                  access;
  logic                  is_io;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0]           rword;
  logic [3:0]            be;
  logic [31:0]           wdata_sh;
  logic [31:0]           rdata_ext;
  logic                  align_err;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign access   = (state == WAIT) && (cnt == 4'd0);
  // Upper address bits are not decoded, so the RAM aliases across the space.
  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  assign is_io    = (addr_q[31:2] == IO_ADDR[31:2]);
  assign rword    = is_io ? ioin : ram[word_idx];

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  lsu_align u_align (
    .addr_lo  (addr_q[1:0]),
    .width    (width_q),
    .we       (we_q),
    .wdata    (wdata_q),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (rdata_ext),
    .err      (align_err)
  );

  // FSM state register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: accept in IDLE, access when the wait count expires,
  // release the response on the consuming handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid)  state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0)    state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Capture the request at acceptance; held unchanged until the next one.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      width_q <= bus.req_width;
    end
  end

  // Wait-state counter and registered response (cleared once consumed).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept)                           cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;

      if (access) begin
        rdata_q <= we_q ? 32'd0 : rdata_ext;
        err_q   <= align_err;
      end else if (bus.resp_valid && bus.resp_ready) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  // Byte-enabled RAM write in the access cycle; IO stores and errors drop.
  always_ff @(posedge clk) begin
    if (access && we_q && !align_err && !is_io) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port, replacing the zero-latency combinational data memory with a valid/ready request/response handshake and a configurable number of wait states.
- Owns the data RAM and the memory-mapped input word (ioin).
- Performs byte/half/word lane steering, sign/zero extension and misalignment detection for every access.
- Sits between the memory stage and the RAM; the hazard unit stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_WIDTH, 17: byte-address bits decoded for the RAM; upper address bits are ignored, so RAM addresses wrap.
- LATENCY, 2: cycles from request acceptance to response; legal range 1..15.
- IO_ADDR, 32'h0001_FFFC: word address that returns ioin on reads and silently ignores writes.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_width  input  3  funct3 encoding: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- resp_valid  output  1  response present
- resp_ready  input  1  core consumes the response
- resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
- resp_err  output  1  misaligned access or illegal width
- ioin  input  32  external input word

Behaviour:
- Reset (rst low, asynchronous): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE: req_ready=1. When req_valid=1 at a clock edge:
  - capture we, addr, wdata and width;
  - load the counter with LATENCY-1;
  - go to WAIT.
- WAIT: req_ready=0. Counter decrements each cycle. The cycle in which the counter is 0 is the access cycle. At that edge:
  - stores write the RAM;
  - loads read the RAM, or sample ioin when the word address equals IO_ADDR;
  - resp_rdata and resp_err are registered;
  - state goes to RESP.
- Timing: a request accepted at edge k gives resp_valid=1 after edge k+LATENCY.
- RESP: resp_valid=1, with resp_rdata and resp_err held stable until resp_ready=1. On the resp_valid&&resp_ready edge:
  - resp_valid drops to 0, and resp_rdata and resp_err return to 0;
  - state returns to IDLE;
  - req_ready=1 in the following cycle. Back-to-back throughput is therefore one transaction per LATENCY+2 cycles.
- Lane steering is little-endian:
  - byte lane = addr[1:0];
  - halfword lane = addr[1];
  - SB/SH write only the selected byte enables; SW writes all four.
  - Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Errors, detected in the access cycle:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - req_width of 011, 110 or 111;
  - store width of 100 or 101.
  - On error: no RAM write, resp_rdata=0, resp_err=1. The response is still delivered through the normal handshake.
- IO address: loads return the ioin value sampled at the access-cycle edge, with the same lane steering. Stores to the IO address are dropped with resp_err=0.
- resp_ready held high in advance does not shorten latency.
- req_valid in WAIT or RESP is ignored and has no side effect.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately. A store not yet at its access-cycle edge does not commit, and no response is issued after reset is released.

Decomposition:
- Shared package mem_pkg:
  - width enum (MW_B=3'b000, MW_H=3'b001, MW_W=3'b010, MW_BU=3'b100, MW_HU=3'b101);
  - FSM state typedef (IDLE, WAIT, RESP);
  - IO_ADDR default constant.
- Sub-module lsu_align, combinational:
  - from addr[1:0], width and data, produces byte-enables, shifted write data, the extended read result and the misalign flag;
  - reused by any future store buffer.

Test Plan:
- LATENCY=2: SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> resp_rdata=0xDEADBEEF, resp_err=0; each resp_valid rises exactly 2 cycles after acceptance.
- Word 0x80706050 at 0x200: LB 0x203 -> 0xFFFFFF80; LBU 0x203 -> 0x00000080; LH 0x202 -> 0xFFFF8070; LHU 0x200 -> 0x00006050.
- SB 0x201 data 0x000000AA over 0x11223344, then LW 0x200 -> 0x1122AA44. SH 0x202 data 0x5555 -> LW returns 0x5555AA44.
- LW 0x102 and SH 0x101 -> resp_err=1, resp_rdata=0. A subsequent LW 0x100 shows the RAM unchanged.
- ioin=0x0000_00C3: LW IO_ADDR -> 0x000000C3. SW IO_ADDR 0x1 -> resp_err=0, and a later LW still returns ioin.
- Handshake and reset:
  - hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready=0;
  - separately, pull rst low during WAIT of SW 0x300 data 0x12345678 -> resp_valid=0 and req_ready=1 immediately, and after release LW 0x300 returns the prior contents.
